// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shifter types,
// NZCV bit positions, multiplier FSM states and a rotate helper.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Rotate right; a rotate of 0 leaves x unchanged (x << 32 yields 0).
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/exe_if.sv
// ID/EXE-facing bundle of the execute stage: decoded instruction fields in,
// ALU/branch/status/stall results out.
interface exe_if;
    logic        flush;
    logic        s;
    logic        imm;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        mul;
    logic [3:0]  exe_cmd;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status_out;
    logic        stall;

    modport master (
        output flush, s, imm, mem_r_en, mem_w_en, b, mul, exe_cmd, pc,
               val_rn, val_rm, shift_operand, signed_imm_24,
        input  alu_result, branch_taken, branch_addr, status_out, stall
    );

    modport slave (
        input  flush, s, imm, mem_r_en, mem_w_en, b, mul, exe_cmd, pc,
               val_rn, val_rm, shift_operand, signed_imm_24,
        output alu_result, branch_taken, branch_addr, status_out, stall
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: latches operands on start, consumes BITS
// multiplier bits per BUSY cycle, holds the 32-bit product for one DONE cycle.
module mul_iter
    import exe_pkg::*;
#(
    parameter int BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_product
);
    localparam int N  = 32 / BITS;
    localparam int CW = $clog2(N);

    mul_state_t    r_state, w_next;
    logic [31:0]   r_a, r_b, r_acc, w_acc_step;
    logic [CW-1:0] r_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= MUL_IDLE;
        else     r_state <= w_next;
    end

    // Next state: flush aborts an operation in flight; DONE lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MUL_IDLE: if (i_start) w_next = MUL_BUSY;
            MUL_BUSY: begin
                if (i_flush)                   w_next = MUL_IDLE;
                else if (r_cnt == CW'(N - 1))  w_next = MUL_DONE;
            end
            MUL_DONE: w_next = MUL_IDLE;
            default:  w_next = MUL_IDLE;
        endcase
    end

    // One step: add the multiplicand for each set bit of the low multiplier digit.
    always_comb begin
        w_acc_step = r_acc;
        for (int j = 0; j < BITS; j++)
            if (r_b[j]) w_acc_step = w_acc_step + (r_a << j);
    end

    // Operand latch, accumulator and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: if (i_start) begin
                    r_a   <= i_a;
                    r_b   <= i_b;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                MUL_BUSY: begin
                    r_acc <= w_acc_step;
                    r_a   <= r_a << BITS;
                    r_b   <= r_b >> BITS;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state == MUL_BUSY);
    assign o_done    = (r_state == MUL_DONE);
    assign o_product = r_acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, ALU with NZCV, branch target, and the
// iterative multiplier that stalls upstream while it runs.
module exe_stage
    import exe_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 2
) (
    input logic clk,
    input logic rst,
    exe_if.slave bus
);
    logic [31:0] w_val2, w_add_b, w_alu, w_product;
    logic [32:0] w_sum;
    logic [4:0]  w_amt;
    logic        w_cin, w_arith, w_flag_en;
    logic [3:0]  w_nzcv;
    logic        w_mul_busy, w_mul_done, w_mul_idle, w_stall;
    logic [3:0]  r_status;

    mul_iter #(.BITS(MUL_BITS_PER_CYCLE)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_start  (bus.mul),
        .i_flush  (bus.flush),
        .i_a      (bus.val_rn),
        .i_b      (bus.val_rm),
        .o_busy   (w_mul_busy),
        .o_done   (w_mul_done),
        .o_product(w_product)
    );

    assign w_mul_idle = ~w_mul_busy & ~w_mul_done;
    assign w_stall    = w_mul_busy | (w_mul_idle & bus.mul);
    assign w_amt      = bus.shift_operand[11:7];

    // Val2: memory offset, rotated immediate, or shifted Rm.
    always_comb begin
        w_val2 = bus.val_rm;
        if (bus.mem_r_en || bus.mem_w_en)
            w_val2 = {20'b0, bus.shift_operand};
        else if (bus.imm)
            w_val2 = ror32({24'b0, bus.shift_operand[7:0]}, {bus.shift_operand[11:8], 1'b0});
        else begin
            case (bus.shift_operand[6:5])
                SH_LSL: w_val2 = bus.val_rm << w_amt;
                SH_LSR: w_val2 = bus.val_rm >> w_amt;
                SH_ASR: w_val2 = 32'($signed(bus.val_rm) >>> w_amt);
                SH_ROR: w_val2 = ror32(bus.val_rm, w_amt);
                default: w_val2 = bus.val_rm;
            endcase
        end
    end

    // ALU: arithmetic ops share one 33-bit adder; subtraction feeds ~Val2.
    always_comb begin
        w_alu     = '0;
        w_add_b   = w_val2;
        w_cin     = 1'b0;
        w_arith   = 1'b0;
        w_flag_en = 1'b1;
        case (bus.exe_cmd)
            CMD_MOV: w_alu = w_val2;
            CMD_MVN: w_alu = ~w_val2;
            CMD_ADD: w_arith = 1'b1;
            CMD_ADC: begin w_arith = 1'b1; w_cin = r_status[NZCV_C]; end
            CMD_SUB: begin w_arith = 1'b1; w_add_b = ~w_val2; w_cin = 1'b1; end
            CMD_SBC: begin w_arith = 1'b1; w_add_b = ~w_val2; w_cin = r_status[NZCV_C]; end
            CMD_AND: w_alu = bus.val_rn & w_val2;
            CMD_ORR: w_alu = bus.val_rn | w_val2;
            CMD_EOR: w_alu = bus.val_rn ^ w_val2;
            default: w_flag_en = 1'b0;
        endcase
        w_sum = {1'b0, bus.val_rn} + {1'b0, w_add_b} + {32'b0, w_cin};
        if (w_arith) w_alu = w_sum[31:0];
    end

    // Flags; logic ops and moves keep C and V.
    always_comb begin
        w_nzcv         = r_status;
        w_nzcv[NZCV_N] = w_alu[31];
        w_nzcv[NZCV_Z] = (w_alu == '0);
        if (w_arith) begin
            w_nzcv[NZCV_C] = w_sum[32];
            w_nzcv[NZCV_V] = (bus.val_rn[31] == w_add_b[31]) && (w_sum[31] != bus.val_rn[31]);
        end
    end

    // Status register: only a live, unstalled instruction may write it.
    always_ff @(posedge clk) begin
        if (rst)
            r_status <= 4'b0000;
        else if (bus.s && !bus.flush && !w_stall) begin
            if (w_mul_done) begin
                r_status[NZCV_N] <= w_product[31];
                r_status[NZCV_Z] <= (w_product == '0);
            end else if (w_flag_en)
                r_status <= w_nzcv;
        end
    end

    assign bus.alu_result   = w_mul_done ? w_product : w_alu;
    assign bus.branch_addr  = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
    assign bus.branch_taken = bus.b & ~bus.flush & ~w_stall;
    assign bus.status_out   = r_status;
    assign bus.stall        = w_stall;

    a_mul_legal: assert property (@(posedge clk) disable iff (rst)
        !(bus.mul && (bus.b || bus.mem_r_en || bus.mem_w_en)));

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage with an arithmetic reference model.
`timescale 1ns/1ps
module tb_exe_stage;
    localparam int BITS  = 2;
    localparam int NSTEP = 32 / BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_if bus();
    exe_stage #(.MUL_BITS_PER_CYCLE(BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] m_status;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rot_r(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> (n % 32);
        return t[31:0];
    endfunction

    function automatic logic [31:0] ref_val2(input logic [31:0] rm, input logic [11:0] so,
                                             input logic imm, input logic mem);
        logic [63:0] t;
        int amt;
        if (mem) return {20'b0, so};
        if (imm) return rot_r({24'b0, so[7:0]}, 2 * int'(so[11:8]));
        amt = int'(so[11:7]);
        case (so[6:5])
            2'd0: return rm << amt;
            2'd1: return rm >> amt;
            2'd2: begin t = {{32{rm[31]}}, rm} >> amt; return t[31:0]; end
            default: return rot_r(rm, amt);
        endcase
    endfunction

    function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, v2,
                                    input logic [3:0] st, output logic [31:0] res,
                                    output logic upd, output logic [3:0] nst);
        longint ua, ub, r, sa, sb, sr, ci;
        logic c, v, arith;
        ua = longint'(a);  ub = longint'(v2);
        sa = longint'($signed(a)); sb = longint'($signed(v2));
        ci = longint'(st[1]);
        c = st[1]; v = st[0]; arith = 1'b1; upd = 1'b1; r = 0; sr = 0; res = '0;
        case (cmd)
            4'd2: begin r = ua + ub;      sr = sa + sb;      c = (r >= 64'h1_0000_0000); end
            4'd3: begin r = ua + ub + ci; sr = sa + sb + ci; c = (r >= 64'h1_0000_0000); end
            4'd4: begin r = ua - ub;      sr = sa - sb;      c = (ua >= ub); end
            4'd5: begin r = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); c = (ua >= ub + (1 - ci)); end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            res = r[31:0];
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else begin
            case (cmd)
                4'd1: res = v2;
                4'd9: res = ~v2;
                4'd6: res = a & v2;
                4'd7: res = a | v2;
                4'd8: res = a ^ v2;
                default: begin res = '0; upd = 1'b0; end
            endcase
        end
        nst = {res[31], res == 32'd0, c, v};
    endfunction

    function automatic logic [31:0] ref_baddr(input logic [31:0] pc, input logic [23:0] off);
        longint o, r;
        o = longint'(off);
        if (o >= 64'd8388608) o = o - 64'd16777216;
        r = longint'(pc) + 4 * o;
        return r[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic alu_op(input logic [3:0] cmd, input logic [31:0] rn, rm, input logic [11:0] so,
                          input logic imm, mr, mw, s, b, fl,
                          input logic [31:0] pc, input logic [23:0] off, input string tag);
        logic [31:0] v2, res;
        logic upd;
        logic [3:0] nst;
        @(negedge clk);
        bus.mul = 1'b0; bus.exe_cmd = cmd; bus.val_rn = rn; bus.val_rm = rm;
        bus.shift_operand = so; bus.imm = imm; bus.mem_r_en = mr; bus.mem_w_en = mw;
        bus.s = s; bus.b = b; bus.flush = fl; bus.pc = pc; bus.signed_imm_24 = off;
        #1;
        v2 = ref_val2(rm, so, imm, mr | mw);
        ref_alu(cmd, rn, v2, m_status, res, upd, nst);
        chk({tag, "_res"},    bus.alu_result, res);
        chk({tag, "_stall"},  32'(bus.stall), 32'd0);
        chk({tag, "_btaken"}, 32'(bus.branch_taken), 32'(b & ~fl));
        chk({tag, "_baddr"},  bus.branch_addr, ref_baddr(pc, off));
        @(posedge clk); #1;
        if (s && !fl && upd) m_status = nst;
        chk({tag, "_nzcv"}, 32'(bus.status_out), 32'(m_status));
    endtask

    // abort_at < 0 runs to completion; otherwise flush (or rst) on that BUSY step.
    task automatic do_mul(input logic [31:0] a, bv, input logic s, input int abort_at,
                          input logic use_rst, input string tag);
        int cnt;
        logic done_seen, aborted;
        logic [31:0] prod;
        longint p;
        p = longint'(a) * longint'(bv);
        prod = p[31:0];
        @(negedge clk);
        bus.mul = 1'b1; bus.b = 1'b0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
        bus.flush = 1'b0; bus.val_rn = a; bus.val_rm = bv; bus.s = s;
        bus.exe_cmd = 4'($urandom_range(0, 15)); bus.imm = 1'($urandom);
        bus.shift_operand = 12'($urandom);
        cnt = 0; done_seen = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!bus.stall) begin done_seen = 1'b1; break; end
            cnt++;
            if (abort_at >= 0 && cnt == abort_at + 1) begin
                if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; bus.flush = 1'b0; bus.mul = 1'b0;
                if (use_rst) m_status = 4'b0000;
                #1;
                chk({tag, "_abort_stall"}, 32'(bus.stall), 32'd0);
                chk({tag, "_abort_nzcv"},  32'(bus.status_out), 32'(m_status));
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!aborted) begin
            chk({tag, "_done_seen"},    32'(done_seen), 32'd1);
            chk({tag, "_stall_cycles"}, 32'(cnt), 32'(NSTEP + 1));
            chk({tag, "_prod"},         bus.alu_result, prod);
            chk({tag, "_hold_nzcv"},    32'(bus.status_out), 32'(m_status));
            @(posedge clk); #1;
            if (s) begin m_status[3] = prod[31]; m_status[2] = (prod == 32'd0); end
            chk({tag, "_nzcv"}, 32'(bus.status_out), 32'(m_status));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.flush = 0; bus.s = 0; bus.imm = 0; bus.mem_r_en = 0; bus.mem_w_en = 0;
        bus.b = 0; bus.mul = 0; bus.exe_cmd = 0; bus.pc = 0; bus.val_rn = 0;
        bus.val_rm = 0; bus.shift_operand = 0; bus.signed_imm_24 = 0;
        m_status = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nzcv",  32'(bus.status_out), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        alu_op(4'b0010, 32'h7FFFFFFF, 32'h0, 12'h001, 1, 0, 0, 1, 0, 0, 32'h0, 24'h0, "add_ovf");
        chk("add_ovf_lit_res",  bus.alu_result, 32'h80000000);
        chk("add_ovf_lit_nzcv", 32'(bus.status_out), 32'b1001);
        alu_op(4'b0100, 32'h5, 32'h5, 12'h000, 0, 0, 0, 1, 0, 0, 32'h0, 24'h0, "sub_zero");
        chk("sub_lit_res",  bus.alu_result, 32'h0);
        chk("sub_lit_nzcv", 32'(bus.status_out), 32'b0110);
        alu_op(4'b0001, 32'h0, 32'h0, 12'h4FF, 1, 0, 0, 0, 0, 0, 32'h0, 24'h0, "mov_imm");
        chk("mov_lit_res", bus.alu_result, 32'hFF000000);
        alu_op(4'b0111, 32'h80000000, 32'h0, 12'h000, 0, 0, 0, 1, 0, 0, 32'h0, 24'h0, "orr_keep");
        chk("orr_lit_nzcv", 32'(bus.status_out), 32'b1010);
        alu_op(4'b0010, 32'h1, 32'h1, 12'h000, 0, 0, 0, 1, 0, 0, 32'h0, 24'h0, "add_clr");
        do_mul(32'h00010003, 32'h5, 1, -1, 0, "mul_dir");
        chk("mul_lit_nzcv", 32'(bus.status_out), 32'b0000);
        do_mul(32'h1234, 32'h5678, 1, 5, 0, "mul_flush");
        do_mul(32'hDEADBEEF, 32'h3, 1, -1, 0, "mul_after_flush");
        do_mul(32'h1234, 32'h5678, 1, 5, 1, "mul_rst");
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1, -1, 0, "mul_after_rst");
        do_mul(32'h00000000, 32'h12345678, 1, -1, 0, "mul_b2b_a");
        do_mul(32'h80000000, 32'h1, 1, -1, 0, "mul_b2b_b");
        alu_op(4'b0000, 32'h0, 32'h0, 12'h000, 0, 0, 0, 0, 1, 0, 32'h100, 24'hFFFFFE, "br");
        chk("br_lit_addr",  bus.branch_addr, 32'h000000F8);
        chk("br_lit_taken", 32'(bus.branch_taken), 32'd1);
        alu_op(4'b0000, 32'h0, 32'h0, 12'h000, 0, 0, 0, 0, 1, 1, 32'h100, 24'hFFFFFE, "br_fl");
        chk("br_fl_lit_taken", 32'(bus.branch_taken), 32'd0);

        // Random mix
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_mul(pick(), pick(), 1'($urandom), -1, 0, "rmul");
            end else begin
                logic mr, mw;
                int m;
                m = $urandom_range(0, 5);
                mr = (m == 0); mw = (m == 1);
                alu_op(4'($urandom_range(0, 15)), pick(), pick(), 12'($urandom),
                       1'($urandom), mr, mw, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0), $urandom, 24'($urandom), "ralu");
            end
        end

        @(negedge clk);
        bus.mul = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage ARM-subset pipeline. It sits directly downstream of the ID/EXE pipeline register and upstream of the EXE/MEM register.
- Combinational datapath: builds Val2, runs the ALU, computes the branch target.
- Sequential state: owns the NZCV status register and an iterative multi-cycle multiplier.
- While a multiply runs, it stalls the upstream stages.

Parameters:
MUL_BITS_PER_CYCLE, 2, multiplier bits consumed per step; legal values 1, 2, 4; step count N = 32/MUL_BITS_PER_CYCLE.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
flush  in  1  kill current EXE instruction (branch taken downstream)
s  in  1  update status register
imm  in  1  shift_operand is rotated immediate
mem_r_en  in  1  load
mem_w_en  in  1  store
b  in  1  branch (condition already resolved in ID)
mul  in  1  instruction is MUL Rd = Rn*Rm
exe_cmd  in  4  ALU opcode
pc  in  32  PC+4 of instruction
val_rn  in  32  operand Rn
val_rm  in  32  operand Rm
shift_operand  in  12  ARM shifter operand field
signed_imm_24  in  24  branch offset
alu_result  out  32  ALU, MUL or address result
branch_taken  out  1  redirect fetch
branch_addr  out  32  branch target
status_out  out  4  registered NZCV, {N,Z,C,V}
stall  out  1  freeze IF/ID/ID-EXE, bubble EXE/MEM

Behaviour:
- Clocking and reset: the single clock is clk. Reset rst is synchronous and active-high.
- State after reset:
  - status register = 4'b0000.
  - Multiplier FSM = IDLE, step counter = 0.
  - stall = 0.
  - All combinational outputs follow their inputs; no reset dependency.
- Val2 generation:
  - If mem_r_en or mem_w_en: Val2 = zero-extended shift_operand[11:0].
  - Else if imm: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Else val_rm is shifted by shift_operand[11:7] using type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes val_rm unchanged.
- ALU opcodes (Val1 = val_rn):
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - Other codes: result 0 and no flag effect.
  - ADC adds C. SUB computes Val1 + ~Val2 + 1; SBC computes Val1 + ~Val2 + C.
  - Loads and stores use 0010, giving an address of Rn + Val2.
- Flags:
  - N = result[31]; Z = (result == 0).
  - Arithmetic ops: C = carry-out of the 33-bit sum; V = operands' signs equal and result sign differs, evaluated on the effective adder operands.
  - Logic ops, MOV, MVN: C and V are preserved.
- Status register update:
  - Writes on a clock edge only when s=1, flush=0 and stall=0.
  - MUL updates N and Z only, in its DONE cycle.
- Branch: branch_addr = pc + sign-extend(signed_imm_24)<<2. branch_taken = b & ~flush & ~stall.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE with mul=1: stall=1 combinationally. The edge latches val_rn and val_rm, clears the accumulator and enters BUSY.
  - BUSY: stall=1. Each cycle performs one shift-add step of MUL_BITS_PER_CYCLE bits. After step N the FSM enters DONE.
  - DONE: stall=0; alu_result = product[31:0]. Returns to IDLE unconditionally on the next edge.
  - Total stall cycles = N+1 (17 at default).
- Boundary cases:
  - flush=1 in BUSY or DONE: return to IDLE on that edge; stall goes low next cycle; no flag update.
  - rst in any state: IDLE on that edge.
  - mul together with b or a memory op is illegal; behaviour is undefined and may be checked by assertion.
  - Back-to-back MULs: the second starts from IDLE one cycle after DONE.
- Widths: internal adder is 33 bits. Product is truncated to 32 bits, so signed and unsigned results are identical.

Decomposition:
- Shared package exe_pkg:
  - EXE_CMD opcode constants.
  - Shift-type constants.
  - NZCV bit indices.
  - Multiplier state enum.
- Natural sub-module: mul_iter (operand latch, accumulator, step counter, FSM), exporting busy and done.
- Val2 generation and the ALU remain inline.

Test Plan:
- ADD, s=1, val_rn=0x7FFFFFFF, imm=1, shift_operand=0x001 -> alu_result=0x80000000; status_out=4'b1001 on the next cycle.
- SUB, s=1, val_rn=val_rm=0x00000005, imm=0, shift_operand=0 -> result 0; status_out=4'b0110.
- MOV, imm=1, shift_operand=0x4FF -> 0xFF000000. ORR with s=1 after the SUB -> C stays 1, V stays 0.
- MUL, val_rn=0x00010003, val_rm=0x00000005:
  - stall high for exactly 17 cycles.
  - DONE cycle: alu_result=0x0005000F; with s=1, status_out=4'b0000.
- MUL aborted mid-operation:
  - flush asserted on BUSY step 5 -> stall low next cycle; status_out unchanged.
  - Repeat with rst in place of flush -> same result, FSM IDLE.
- Branch: b=1, pc=0x00000100, signed_imm_24=0xFFFFFE -> branch_addr=0x000000F8, branch_taken=1; same stimulus with flush=1 -> branch_taken=0.
